// File: rtl/decoder_pkg.sv
// Shared types and defaults for the scanning one-hot decoder.
package decoder_pkg;

  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  function automatic state_e next_state(input logic en, input logic mode);
    if (!en) return IDLE;
    return mode ? SCAN : DIRECT;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational select-to-one-hot decode; all lines low when disabled.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    en_i,
  input  logic [ADDR_W-1:0]       sel_i,
  output logic [(1<<ADDR_W)-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// One-hot line decoder with direct select and auto-scan modes, each scanned
// line held dwell+1 cycles, with a wrap pulse when the scan returns to line 0.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    addr_valid,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<ADDR_W)-1:0]  dout,
  output logic [ADDR_W-1:0]       cur_addr,
  output logic                    wrap
);

  localparam int LINES = 1 << ADDR_W;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwl_q, dwl_d;
  logic [LINES-1:0]     dout_q, dout_d;
  logic                 wrap_q, wrap_d;
  logic                 out_en;

  always_comb begin
    state_d = next_state(en, mode);
  end

  // A load always wins over a scan advance; a channel (re)start samples dwell.
  always_comb begin
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    dwl_d      = dwl_q;
    wrap_d     = 1'b0;
    if (addr_valid) begin
      cur_addr_d = addr;
      cnt_d      = '0;
      dwl_d      = dwell;
    end else if (state_d == SCAN) begin
      if (state_q != SCAN) begin
        cnt_d = '0;
        dwl_d = dwell;
      end else if (cnt_q == dwl_q) begin
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        cnt_d      = '0;
        dwl_d      = dwell;
        wrap_d     = (cur_addr_q == '1);
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign out_en = (state_d != IDLE);

  decoder_onehot #(.ADDR_W(ADDR_W)) u_onehot (
    .en_i     (out_en),
    .sel_i    (cur_addr_d),
    .onehot_o (dout_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      dwl_q      <= dwl_d;
      dout_q     <= dout_d;
      wrap_q     <= wrap_d;
    end
  end

  assign dout     = dout_q;
  assign cur_addr = cur_addr_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: directed scenarios on the default
// configuration plus a random sweep across ADDR_W = 1, 2, 3, 4.
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, av;
  logic [3:0] addr_r, dwell_r;

  logic [1:0]  dout1; logic [0:0] cur1; logic wrap1;
  logic [3:0]  dout2; logic [1:0] cur2; logic wrap2;
  logic [7:0]  dout3; logic [2:0] cur3; logic wrap3;
  logic [15:0] dout4; logic [3:0] cur4; logic wrap4;

  decoder_scan u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr_r[1:0]),
    .addr_valid(av), .dwell(dwell_r), .dout(dout2), .cur_addr(cur2), .wrap(wrap2)
  );
  decoder_scan #(.ADDR_W(1)) u_a1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr_r[0:0]),
    .addr_valid(av), .dwell(dwell_r), .dout(dout1), .cur_addr(cur1), .wrap(wrap1)
  );
  decoder_scan #(.ADDR_W(3)) u_a3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr_r[2:0]),
    .addr_valid(av), .dwell(dwell_r), .dout(dout3), .cur_addr(cur3), .wrap(wrap3)
  );
  decoder_scan #(.ADDR_W(4)) u_a4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr_r),
    .addr_valid(av), .dwell(dwell_r), .dout(dout4), .cur_addr(cur4), .wrap(wrap4)
  );

  typedef struct packed {
    logic       rst, en, mode, av;
    logic [3:0] addr, dwell;
    logic [3:0] dout;
    logic [1:0] cur;
    logic       wrap;
  } step_t;

  typedef struct packed {
    logic [15:0] dout;
    logic [3:0]  cur;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int m_st[4], m_cur[4], m_left[4];

  function automatic step_t st(input logic r, e, m, v, input logic [3:0] a, d, od,
                               input logic [1:0] oc, input logic ow);
    step_t s;
    s.rst = r; s.en = e; s.mode = m; s.av = v; s.addr = a; s.dwell = d;
    s.dout = od; s.cur = oc; s.wrap = ow;
    return s;
  endfunction

  task automatic apply(input step_t s);
    rst = s.rst; en = s.en; mode = s.mode; av = s.av; addr_r = s.addr; dwell_r = s.dwell;
  endtask

  task automatic test_reset();
    step_t tbl[$];
    tbl.push_back(st(1,1,1,1,3,0, 4'b0000,0,0));
    tbl.push_back(st(1,1,1,0,0,0, 4'b0000,0,0));
    tbl.push_back(st(1,1,1,0,0,0, 4'b0000,0,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0001,0,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0010,1,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0100,2,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b1000,3,0));
    tbl.push_back(st(1,1,1,0,0,0, 4'b0000,0,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0001,0,0));
    foreach (tbl[i]) begin
      exp_t e, g;
      apply(tbl[i]);
      sb.push_back('{dout: 16'(tbl[i].dout), cur: 4'(tbl[i].cur), wrap: tbl[i].wrap});
      @(posedge clk); #1;
      e = sb.pop_front();
      g = '{dout: 16'(dout2), cur: 4'(cur2), wrap: wrap2};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset step %0d: got dout=%b cur=%0d wrap=%b, expected dout=%b cur=%0d wrap=%b",
                 i, g.dout[3:0], g.cur, g.wrap, e.dout[3:0], e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_direct();
    step_t tbl[$];
    tbl.push_back(st(1,1,0,0,0,0, 4'b0000,0,0));
    tbl.push_back(st(0,1,0,1,2,0, 4'b0100,2,0));
    for (int k = 0; k < 10; k++) tbl.push_back(st(0,1,0,0,1,0, 4'b0100,2,0));
    tbl.push_back(st(0,1,0,1,3,0, 4'b1000,3,0));
    tbl.push_back(st(0,0,0,1,1,0, 4'b0000,1,0));
    tbl.push_back(st(0,1,0,0,0,0, 4'b0010,1,0));
    foreach (tbl[i]) begin
      exp_t e, g;
      apply(tbl[i]);
      sb.push_back('{dout: 16'(tbl[i].dout), cur: 4'(tbl[i].cur), wrap: tbl[i].wrap});
      @(posedge clk); #1;
      e = sb.pop_front();
      g = '{dout: 16'(dout2), cur: 4'(cur2), wrap: wrap2};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL direct step %0d: got dout=%b cur=%0d wrap=%b, expected dout=%b cur=%0d wrap=%b",
                 i, g.dout[3:0], g.cur, g.wrap, e.dout[3:0], e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_scan_dwell1();
    step_t tbl[$];
    tbl.push_back(st(1,1,1,0,0,1, 4'b0000,0,0));
    for (int k = 0; k < 10; k++) begin
      logic [1:0] c;
      logic [3:0] oh;
      c  = 2'((k / 2) % 4);
      oh = 4'b0001 << c;
      tbl.push_back(st(0,1,1,0,0,1, oh, c, (k == 8)));
    end
    foreach (tbl[i]) begin
      exp_t e, g;
      apply(tbl[i]);
      sb.push_back('{dout: 16'(tbl[i].dout), cur: 4'(tbl[i].cur), wrap: tbl[i].wrap});
      @(posedge clk); #1;
      e = sb.pop_front();
      g = '{dout: 16'(dout2), cur: 4'(cur2), wrap: wrap2};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL scan_dwell1 step %0d: got dout=%b cur=%0d wrap=%b, expected dout=%b cur=%0d wrap=%b",
                 i, g.dout[3:0], g.cur, g.wrap, e.dout[3:0], e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_load_wins();
    step_t tbl[$];
    tbl.push_back(st(1,1,1,0,0,0, 4'b0000,0,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0001,0,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0010,1,0));
    tbl.push_back(st(0,1,1,1,3,0, 4'b1000,3,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0001,0,1));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0010,1,0));
    tbl.push_back(st(0,1,1,1,3,0, 4'b1000,3,0));
    tbl.push_back(st(0,1,1,1,0,0, 4'b0001,0,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0010,1,0));
    foreach (tbl[i]) begin
      exp_t e, g;
      apply(tbl[i]);
      sb.push_back('{dout: 16'(tbl[i].dout), cur: 4'(tbl[i].cur), wrap: tbl[i].wrap});
      @(posedge clk); #1;
      e = sb.pop_front();
      g = '{dout: 16'(dout2), cur: 4'(cur2), wrap: wrap2};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL load_wins step %0d: got dout=%b cur=%0d wrap=%b, expected dout=%b cur=%0d wrap=%b",
                 i, g.dout[3:0], g.cur, g.wrap, e.dout[3:0], e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_en_drop();
    step_t tbl[$];
    tbl.push_back(st(1,1,1,0,0,1, 4'b0000,0,0));
    tbl.push_back(st(0,1,1,1,2,1, 4'b0100,2,0));
    tbl.push_back(st(0,1,1,0,0,1, 4'b0100,2,0));
    for (int k = 0; k < 4; k++) tbl.push_back(st(0,0,1,0,0,1, 4'b0000,2,0));
    tbl.push_back(st(0,1,1,0,0,3, 4'b0100,2,0));
    for (int k = 0; k < 3; k++) tbl.push_back(st(0,1,1,0,0,0, 4'b0100,2,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b1000,3,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0001,0,1));
    foreach (tbl[i]) begin
      exp_t e, g;
      apply(tbl[i]);
      sb.push_back('{dout: 16'(tbl[i].dout), cur: 4'(tbl[i].cur), wrap: tbl[i].wrap});
      @(posedge clk); #1;
      e = sb.pop_front();
      g = '{dout: 16'(dout2), cur: 4'(cur2), wrap: wrap2};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL en_drop step %0d: got dout=%b cur=%0d wrap=%b, expected dout=%b cur=%0d wrap=%b",
                 i, g.dout[3:0], g.cur, g.wrap, e.dout[3:0], e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_mode_dwell_max();
    step_t tbl[$];
    tbl.push_back(st(1,1,0,0,0,15, 4'b0000,0,0));
    tbl.push_back(st(0,1,0,1,1,15, 4'b0010,1,0));
    tbl.push_back(st(0,1,0,0,0,15, 4'b0010,1,0));
    for (int k = 0; k < 16; k++) tbl.push_back(st(0,1,1,0,0,15, 4'b0010,1,0));
    tbl.push_back(st(0,1,1,0,0,15, 4'b0100,2,0));
    for (int k = 0; k < 3; k++) tbl.push_back(st(0,1,0,0,0,0, 4'b0100,2,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b0100,2,0));
    tbl.push_back(st(0,1,1,0,0,0, 4'b1000,3,0));
    foreach (tbl[i]) begin
      exp_t e, g;
      apply(tbl[i]);
      sb.push_back('{dout: 16'(tbl[i].dout), cur: 4'(tbl[i].cur), wrap: tbl[i].wrap});
      @(posedge clk); #1;
      e = sb.pop_front();
      g = '{dout: 16'(dout2), cur: 4'(cur2), wrap: wrap2};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL mode_dwell_max step %0d: got dout=%b cur=%0d wrap=%b, expected dout=%b cur=%0d wrap=%b",
                 i, g.dout[3:0], g.cur, g.wrap, e.dout[3:0], e.cur, e.wrap);
      end
    end
  endtask

  // Countdown reference: m_left is the number of further cycles on the current line.
  task automatic test_sweep();
    mode = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rst     = (cyc == 0) || ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      av      = ($urandom_range(0, 7) == 0);
      addr_r  = 4'($urandom);
      dwell_r = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      for (int w = 0; w < 4; w++) begin
        int   lines, nst;
        logic mw;
        logic [15:0] ed;
        lines = 1 << (w + 1);
        nst   = !en ? 0 : (mode ? 2 : 1);
        mw    = 1'b0;
        if (rst) begin
          m_st[w] = 0; m_cur[w] = 0; m_left[w] = 0; nst = 0;
        end else begin
          if (av) begin
            m_cur[w]  = int'(addr_r) % lines;
            m_left[w] = int'(dwell_r);
          end else if (nst == 2) begin
            if (m_st[w] != 2) m_left[w] = int'(dwell_r);
            else if (m_left[w] == 0) begin
              mw        = (m_cur[w] == lines - 1);
              m_cur[w]  = (m_cur[w] + 1) % lines;
              m_left[w] = int'(dwell_r);
            end else m_left[w]--;
          end
          m_st[w] = nst;
        end
        ed = (nst != 0) ? (16'd1 << m_cur[w]) : 16'd0;
        sb.push_back('{dout: ed, cur: 4'(m_cur[w]), wrap: mw});
      end
      @(posedge clk); #1;
      for (int w = 0; w < 4; w++) begin
        exp_t e, g;
        e = sb.pop_front();
        case (w)
          0:       g = '{dout: 16'(dout1), cur: 4'(cur1), wrap: wrap1};
          1:       g = '{dout: 16'(dout2), cur: 4'(cur2), wrap: wrap2};
          2:       g = '{dout: 16'(dout3), cur: 4'(cur3), wrap: wrap3};
          default: g = '{dout: dout4,      cur: cur4,     wrap: wrap4};
        endcase
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL sweep aw=%0d cyc %0d: got dout=%h cur=%0d wrap=%b, expected dout=%h cur=%0d wrap=%b",
                   w + 1, cyc, g.dout, g.cur, g.wrap, e.dout, e.cur, e.wrap);
        end
        checks++;
        if ($countones(g.dout) > 1) begin
          failures++;
          $display("FAIL sweep_onehot aw=%0d cyc %0d: got dout=%h, expected at most one bit set",
                   w + 1, cyc, g.dout);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; av = 1'b0; addr_r = '0; dwell_r = '0;
    test_reset();
    test_direct();
    test_scan_dwell1();
    test_load_wins();
    test_en_drop();
    test_mode_dwell_max();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
